// File: rtl/swd_frontend_top.sv
// ============================================================================
// swd_frontend_top
// ----------------------------------------------------------------------------
// SPI-slave to SWD bit-level frontend. The MCU clocks one SWD wire transaction
// through its SPI port. A frame bit counter decides, bit by bit, who owns the
// SWD data line:
//   - host-owned bits pass from mosi onto swdio
//   - target-owned bits pass from swdio back onto miso
// One frame is run per reset release. The MCU re-arms the block, or aborts a
// frame in progress, by pulsing rst_n low.
//
// Ports:
//   sck             in    SPI clock and the only clock. The rising edge is the
//                         SWD sample edge and the falling edge advances the bit.
//   rst_n           in    asynchronous active-low reset, also the frame arm and
//                         abort strobe
//   mosi            in    host bit stream, which changes on sck falling edges
//   miso            out   target bit stream returned to the MCU
//   rnw             in    1 = read frame, 0 = write frame
//   output_enable_n in    active-low global enable for the SWD pins
//   swclk           out   SWD clock
//   swdio           inout SWD data, tri-stated unless the host owns the bit
//
// Parameters:
//   PAD_BITS        number of leading host-driven low pad bits (default 2)
//
// Optional feature (compile-time macro SWD_PARITY_GEN_EN):
//   When defined, write-data parity is generated internally and driven in
//   the parity slot, and mosi is ignored there. When undefined, the parity
//   bit passes through from mosi like any other host bit.
// ============================================================================
module swd_frontend_top #(
    parameter int PAD_BITS = 2
) (
    input  logic sck,
    input  logic rst_n,
    input  logic mosi,
    output logic miso,
    input  logic rnw,
    input  logic output_enable_n,
    output logic swclk,
    inout  wire  swdio
);

    // Frame landmarks. Every index shifts with the number of pad bits.
    localparam logic [5:0] L_REQ_FIRST   = 6'(PAD_BITS);
    localparam logic [5:0] L_TURN1       = 6'(PAD_BITS + 8);
    localparam logic [5:0] L_ACK_LAST    = 6'(PAD_BITS + 11);
    localparam logic [5:0] L_TURN2       = 6'(PAD_BITS + 12);
    localparam logic [5:0] L_RDATA_LAST  = 6'(PAD_BITS + 43);
    localparam logic [5:0] L_RPARITY     = 6'(PAD_BITS + 44);
    localparam logic [5:0] L_WDATA_LAST  = 6'(PAD_BITS + 44);
    localparam logic [5:0] L_LAST_SLOT   = 6'(PAD_BITS + 45);
    localparam logic [5:0] L_FRAME_END   = 6'(PAD_BITS + 46);

    typedef enum logic [3:0] {
        PH_PAD,
        PH_REQ,
        PH_TURN,
        PH_ACK,
        PH_WDATA,
        PH_WPARITY,
        PH_RDATA,
        PH_RPARITY,
        PH_DONE
    } phase_t;

    logic [5:0] r_cnt;
    phase_t     w_phase;
    logic       w_hostOwned;
    logic       w_targetOwned;
    logic       w_frameActive;
    logic       w_pinsEnabled;
    logic       w_drive;
    logic       w_hostBit;

    // Bit counter. It advances on the falling edge, so r_cnt is stable
    // across the rising edge where SWD samples. A falling edge that arrives
    // while rst_n is still low is absorbed by the reset, so the edge that
    // coincides with reset release does not count. The counter stops at
    // frame end and stays there until the next reset.
    always_ff @(negedge sck or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt != L_FRAME_END) begin
            r_cnt <= r_cnt + 6'd1;
        end
    end

    // Phase decode. Requests, the first turnaround and ACK are common to
    // both directions. After ACK, a write frame inserts a second turnaround
    // before the host data. A read frame goes straight into target data and
    // ends with a turnaround in the slot where a write frame has its parity.
    always_comb begin
        w_phase = PH_DONE;
        if (r_cnt < L_REQ_FIRST) begin
            w_phase = PH_PAD;
        end else if (r_cnt < L_TURN1) begin
            w_phase = PH_REQ;
        end else if (r_cnt == L_TURN1) begin
            w_phase = PH_TURN;
        end else if (r_cnt <= L_ACK_LAST) begin
            w_phase = PH_ACK;
        end else if (rnw) begin
            if (r_cnt <= L_RDATA_LAST) begin
                w_phase = PH_RDATA;
            end else if (r_cnt == L_RPARITY) begin
                w_phase = PH_RPARITY;
            end else if (r_cnt == L_LAST_SLOT) begin
                w_phase = PH_TURN;
            end
        end else begin
            if (r_cnt == L_TURN2) begin
                w_phase = PH_TURN;
            end else if (r_cnt <= L_WDATA_LAST) begin
                w_phase = PH_WDATA;
            end else if (r_cnt == L_LAST_SLOT) begin
                w_phase = PH_WPARITY;
            end
        end
    end

    // Line ownership for the current bit. Any phase not listed here,
    // including the turnarounds and the done state, leaves swdio floating
    // and miso low.
    always_comb begin
        w_hostOwned   = 1'b0;
        w_targetOwned = 1'b0;
        case (w_phase)
            PH_PAD, PH_REQ, PH_WDATA, PH_WPARITY: w_hostOwned   = 1'b1;
            PH_ACK, PH_RDATA, PH_RPARITY:         w_targetOwned = 1'b1;
            default: begin
                w_hostOwned   = 1'b0;
                w_targetOwned = 1'b0;
            end
        endcase
    end

`ifdef SWD_PARITY_GEN_EN
    logic r_parityAcc;

    // Running XOR of the write data bits, captured on the same rising edges
    // at which the target samples them. The value is ready in the parity
    // slot that immediately follows the last data bit.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            r_parityAcc <= 1'b0;
        end else if (w_phase == PH_WDATA) begin
            r_parityAcc <= r_parityAcc ^ mosi;
        end
    end

    assign w_hostBit = (w_phase == PH_WPARITY) ? r_parityAcc : mosi;
`else
    assign w_hostBit = mosi;
`endif

    // Pin drivers. Everything is combinational, so host bits reach swdio
    // and target bits reach miso with no added latency. r_cnt changes only
    // on falling edges and output_enable_n is expected to be stable while
    // sck is high, so the swclk gate can only switch while sck is low. This
    // keeps swclk free of glitches.
    assign w_frameActive = (r_cnt < L_FRAME_END);
    assign w_pinsEnabled = rst_n & ~output_enable_n;
    assign w_drive       = w_pinsEnabled & w_hostOwned;

    assign swdio = w_drive ? w_hostBit : 1'bz;
    assign miso  = rst_n & w_targetOwned & swdio;
    assign swclk = sck & w_pinsEnabled & w_frameActive;

endmodule

// File: tb/tb_swd_frontend_top.sv
// ============================================================================
// tb_swd_frontend_top
// ----------------------------------------------------------------------------
// Self-checking bench for swd_frontend_top with the default PAD_BITS of 2.
// Each frame bit is driven shortly after a falling sck edge. At the same time
// the expected pin values are pushed to a scoreboard queue. They are popped
// and compared one time unit after the next rising edge.
// When swdio should float, mosi is held at 1 and the bench does not drive
// the line, so a leaking host driver shows up as swdio reading 1.
// ============================================================================
module tb_swd_frontend_top;

    logic sck             = 1'b0;
    logic rst_n           = 1'b0;
    logic mosi            = 1'b0;
    logic rnw             = 1'b0;
    logic output_enable_n = 1'b0;
    logic miso;
    logic swclk;
    wire  swdio;

    logic tbDrive = 1'b0;
    logic tbVal   = 1'b0;

    int errors = 0;
    int checks = 0;

    // Target side of the SWD wire
    assign swdio = tbDrive ? tbVal : 1'bz;

    swd_frontend_top #(.PAD_BITS(2)) dut (
        .sck             (sck),
        .rst_n           (rst_n),
        .mosi            (mosi),
        .miso            (miso),
        .rnw             (rnw),
        .output_enable_n (output_enable_n),
        .swclk           (swclk),
        .swdio           (swdio)
    );

    always #5 sck = ~sck;

    typedef struct {
        int   bitIdx;
        bit   hostOwned;
        logic expSwdio;
        bit   tgtOwned;
        logic expMiso;
        logic expSwclk;
    } exp_t;

    exp_t sb[$];

    // Settings for the frame that is currently running
    bit          frIsRead;
    logic [7:0]  frReq;
    logic [31:0] frData;
    logic        frPar;
    logic [2:0]  frAck;
    bit          frOeN;

    // Drives mosi and the target for frame bit b and records the expected
    // pins. The bit map is derived from the SWD wire protocol with 2 pad bits.
    task automatic applyStimulus(input int b);
        exp_t e;
        bit   host   = 1'b0;
        bit   tgt    = 1'b0;
        logic hBit   = 1'b1;
        logic hExp   = 1'b1;
        logic tBit   = 1'b0;
        if (b < 2) begin
            host = 1'b1; hBit = 1'b0;
        end else if (b < 10) begin
            host = 1'b1; hBit = frReq[b - 2];
        end else if (b == 10) begin
            host = 1'b0;
        end else if (b < 14) begin
            tgt = 1'b1; tBit = frAck[b - 11];
        end else if (b < 48) begin
            if (!frIsRead) begin
                if (b >= 15 && b < 47) begin
                    host = 1'b1; hBit = frData[b - 15];
                end else if (b == 47) begin
                    host = 1'b1; hBit = frPar;
                end
            end else begin
                if (b < 46) begin
                    tgt = 1'b1; tBit = frData[b - 14];
                end else if (b == 46) begin
                    tgt = 1'b1; tBit = frPar;
                end
            end
        end
        hExp = hBit;
`ifdef SWD_PARITY_GEN_EN
        if (!frIsRead && b == 47) hExp = ^frData;
`endif
        mosi    = host ? hBit : 1'b1;
        tbDrive = tgt;
        tbVal   = tBit;
        e.bitIdx    = b;
        e.hostOwned = host && !frOeN;
        e.expSwdio  = hExp;
        e.tgtOwned  = tgt;
        e.expMiso   = tgt ? tBit : 1'b0;
        e.expSwclk  = (b < 48) && !frOeN;
        sb.push_back(e);
    endtask

    // Runs one frame from reset release through five sck cycles past the end
    // of the frame, or stops after bit abortAt has been checked.
    task automatic runFrame(input string tag, input int abortAt);
        exp_t e;
        rnw             = frIsRead;
        output_enable_n = frOeN;
        @(negedge sck); #1;
        rst_n = 1'b1;
        for (int b = 0; b < 53; b++) begin
            if (b > 0) begin
                @(negedge sck); #1;
            end
            applyStimulus(b);
            @(posedge sck); #1;
            e = sb.pop_front();
            checks++;
            if (swclk !== e.expSwclk) begin
                errors++;
                $display("[TB] FAIL %s_swclk bit %0d: got %b want %b", tag, e.bitIdx, swclk, e.expSwclk);
            end
            if (e.hostOwned) begin
                checks++;
                if (swdio !== e.expSwdio) begin
                    errors++;
                    $display("[TB] FAIL %s_swdio bit %0d: got %b want %b", tag, e.bitIdx, swdio, e.expSwdio);
                end
            end else if (!e.tgtOwned) begin
                checks++;
                if (swdio === 1'b1) begin
                    errors++;
                    $display("[TB] FAIL %s_swdio_z bit %0d: got %b want z", tag, e.bitIdx, swdio);
                end
            end
            checks++;
            if (miso !== e.expMiso) begin
                errors++;
                $display("[TB] FAIL %s_miso bit %0d: got %b want %b", tag, e.bitIdx, miso, e.expMiso);
            end
            if (b == abortAt) begin
                tbDrive = 1'b0;
                mosi    = 1'b1;
                rst_n   = 1'b0;
                #1;
                checks++;
                if (swclk !== 1'b0 || miso !== 1'b0 || swdio === 1'b1) begin
                    errors++;
                    $display("[TB] FAIL %s_abort_pins: got swclk=%b miso=%b swdio=%b want 0 0 z", tag, swclk, miso, swdio);
                end
                break;
            end
        end
        tbDrive = 1'b0;
        mosi    = 1'b0;
        rst_n   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        mosi    = 1'b1;
        tbDrive = 1'b0;
        output_enable_n = 1'b0;
        repeat (4) begin
            @(posedge sck); #1;
            checks++;
            if (swclk !== 1'b0 || miso !== 1'b0 || swdio === 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_pins: got swclk=%b miso=%b swdio=%b want 0 0 z", swclk, miso, swdio);
            end
        end
        // Release at a falling edge. A 1 on the pad bit makes the host
        // driver visible before the next rising edge.
        @(negedge sck); #1;
        rst_n = 1'b1;
        #2;
        checks++;
        if (swdio !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_first_bit: got %b want 1", swdio);
        end
        rst_n = 1'b0;
        mosi  = 1'b0;
    endtask

    task automatic test_write_ok();
        frIsRead = 1'b0; frReq = 8'hA1; frData = 32'hCAFEBABE;
        frPar = 1'b0; frAck = 3'b001; frOeN = 1'b0;
        runFrame("write", -1);
    endtask

    task automatic test_read_ok();
        frIsRead = 1'b1; frReq = 8'hA5; frData = 32'h12345678;
        frPar = 1'b1; frAck = 3'b001; frOeN = 1'b0;
        runFrame("read", -1);
    endtask

    task automatic test_output_disable();
        frIsRead = 1'b0; frReq = 8'hA1; frData = 32'hCAFEBABE;
        frPar = 1'b0; frAck = 3'b001; frOeN = 1'b1;
        runFrame("oe_off", -1);
        output_enable_n = 1'b0;
    endtask

    task automatic test_abort_restart();
        frIsRead = 1'b0; frReq = 8'hA1; frData = 32'hCAFEBABE;
        frPar = 1'b0; frAck = 3'b001; frOeN = 1'b0;
        runFrame("abort", 20);
        repeat (2) @(posedge sck);
        frIsRead = 1'b1; frReq = 8'hA5; frData = 32'h0F0F00FF;
        frPar = 1'b0; frAck = 3'b001; frOeN = 1'b0;
        runFrame("restart", -1);
    endtask

    task automatic test_parity();
        frIsRead = 1'b0; frReq = 8'hA1; frData = 32'h00000001;
        frPar = 1'b0; frAck = 3'b001; frOeN = 1'b0;
        runFrame("parity", -1);
    endtask

    initial begin
        $display("[TB] starting swd_frontend_top bench");
        test_reset();
        test_write_ok();
        test_read_ok();
        test_output_disable();
        test_abort_restart();
        test_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] time limit reached");
    end

endmodule

// File: doc/swd_frontend_top.md
Name: swd_frontend_top

Overview:
- SPI-slave-to-SWD bit-level frontend: converts the SPI stream (sck, mosi, miso) into one SWD wire transaction on swclk/swdio.
- Decodes bus ownership per bit from a frame bit counter: host bits on mosi pass to swdio; target bits on swdio pass to miso.
- Sits between the SPI master (MCU) and the SWD target connector.
- One frame per reset-release; the MCU re-arms the block by pulsing rst_n low.

Parameters:
- PAD_BITS, default 2: number of leading host-driven low pad bits. All bit indices below are for PAD_BITS=2; other values shift them by PAD_BITS-2.

Ports:
- sck  in  1  SPI clock, the sole clock. Rising edge = SWD sample edge; falling edge = bit advance.
- rst_n  in  1  asynchronous active-low reset; also the frame arm/abort strobe.
- mosi  in  1  host bit stream; MCU changes it on sck falling edges.
- miso  out  1  target bit stream back to the MCU.
- rnw  in  1  1 = read frame, 0 = write frame; stable while rst_n is high.
- output_enable_n  in  1  active-low global enable for the SWD pins.
- swclk  out  1  SWD clock.
- swdio  inout  1  SWD bidirectional data, tri-stated when not owned by the host.

Behaviour:
- Bit counter cnt (6 bits), clocked on sck falling edge, async cleared by rst_n low. A falling edge coincident with reset release does not count. Increments by 1 per falling edge; saturates at 48 (frame done). cnt=i spans the rising edge of SWD bit i.
- Reset (rst_n=0): cnt=0, swclk=0, swdio=Z, miso=0.
- swclk = sck AND rst_n AND (cnt<48) AND NOT output_enable_n. Gating changes only while sck is low, so swclk is glitch-free.
- Write frame phase map (rnw=0):
  - cnt 0-1: pad; swdio driven = mosi (0 expected).
  - cnt 2-9: request bits 0..7 LSB first; swdio = mosi.
  - cnt 10: turnaround; swdio = Z.
  - cnt 11-13: ACK[0..2]; swdio = Z; miso = swdio.
  - cnt 14: turnaround 2; swdio = Z.
  - cnt 15-46: write data bits 0..31; swdio = mosi.
  - cnt 47: parity; swdio = mosi.
- Read frame phase map (rnw=1):
  - cnt 0-13: same as the write frame.
  - cnt 14-45: read data bits 0..31; swdio = Z; miso = swdio.
  - cnt 46: parity; swdio = Z; miso = swdio.
  - cnt 47: turnaround; swdio = Z.
- cnt >= 48: swdio = Z, miso = 0, swclk held low until the next reset.
- miso = 0 in every cnt not listed above as target-owned. The swdio-to-miso path and the mosi-to-swdio path are combinational, with no added latency.
- output_enable_n=1: swdio = Z and swclk = 0 regardless of phase. The counter keeps running; miso still follows the phase map.
- rst_n low mid-frame aborts immediately: pins go to their reset values and no partial state is retained.
- Read swdio as 0 when floating (no bus keeper inside).

Optional Feature:
- Macro SWD_PARITY_GEN_EN.
  - Defined: an internal XOR accumulator captures each write data bit at sck rising edges cnt 15-46 (cleared by reset). At cnt 47, swdio drives the accumulator value and mosi is ignored.
  - Undefined: parity is passed through from mosi like any other host bit.

Test Plan:
- Write OK, REQ=0xA1, DATA=0xCAFEBABE:
  - swdio at each rising sck = 0,0 then 1,0,0,0,0,1,0,1.
  - Z at cnt 10 and 14.
  - Target drives ACK 1,0,0 at cnt 11-13; miso reads 1,0,0 at the following falling edges.
  - swdio = 0xCAFEBABE LSB first at cnt 15-46; parity 0 at cnt 47.
- Read OK, REQ=0xA5, rnw=1: target drives 0x12345678 and parity 1 at cnt 14-46 -> miso mirrors each bit; swdio never host-driven after cnt 9.
- Reset: hold rst_n=0 across 4 sck cycles -> swclk 0, swdio Z, miso 0. Release at a falling edge -> first host bit is driven before the next rising edge.
- output_enable_n=1 throughout a write frame -> swdio Z and swclk 0 at all bits.
- Abort: rst_n low at cnt 20, then a fresh frame -> bit numbering restarts at 0. Frame end: after cnt 47, swclk stays 0 for 5 extra sck cycles.
- With SWD_PARITY_GEN_EN, DATA=0x00000001 with mosi parity deliberately 0 -> swdio at cnt 47 = 1.
